// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package rr_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 8,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant
);

  logic [SEL_W-1:0] idx;

  // Scan offsets from the far end so the offset closest to ptr is the last writer.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = SEL_W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 packet-aware stream mux: round-robin or forced source, grant held per packet,
// single registered output stage.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [W-1:0]     data_arr [N];
  logic             rr_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic             ld;
  logic             xfer;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = in_data[i*W +: W];
  end

  rr_arbiter #(.N(N)) u_arbiter (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_valid (rr_valid),
    .grant       (rr_grant)
  );

  assign ld = !out_valid_q || out_ready;

  // Mode inputs are only looked at between packets; a locked packet keeps its channel.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (state_q == LOCK) begin
      grant       = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end else if (force_en) begin
      grant       = force_sel;
      grant_valid = (int'(force_sel) < N) && in_valid[force_sel];
    end else begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end
  end

  // Reset gates ready so no producer sees a beat accepted that is about to be discarded.
  assign xfer = ld && grant_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (ld) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = data_arr[grant];
        out_last_d = in_last[grant];
        out_sel_d  = grant;
      end
    end

    if (xfer) begin
      if (in_last[grant]) begin
        state_d = IDLE;
        if (!force_en) begin
          ptr_d = (int'(grant) == N - 1) ? '0 : grant + SEL_W'(1);
        end
      end else begin
        state_d   = LOCK;
        lock_ch_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule
